// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor: captures retired instructions into a commit FIFO, keeps a shadow register file, stops after halt
module commit_trace_monitor #(
    parameter int          XLEN       = 32,
    parameter int          DEPTH      = 8,
    parameter logic [31:0] HALT_INSTR = 32'h0010_0073
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [4:0]      reg_addr_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic            stall_i,
    output logic            trace_valid_o,
    input  logic            trace_ready_i,
    output logic [XLEN-1:0] trace_pc_o,
    output logic [XLEN-1:0] trace_instr_o,
    output logic [4:0]      trace_rd_addr_o,
    output logic [XLEN-1:0] trace_rd_data_o,
    output logic [31:0]     trace_seq_o,
    input  logic [4:0]      dbg_addr_i,
    output logic [XLEN-1:0] dbg_data_o,
    output logic [31:0]     retired_o,
    output logic [15:0]     dropped_o,
    output logic            overflow_o,
    output logic            halted_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [AW-1:0]   wr_idx, rd_idx;
    logic            empty, full, commit, push, pop, drop, rf_we, is_halt;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [4:0]      rd_mem    [DEPTH];
    logic [XLEN-1:0] data_mem  [DEPTH];
    logic [31:0]     seq_mem   [DEPTH];
    logic [XLEN-1:0] rf        [32];

    assign wr_idx  = wr_ptr[AW-1:0];
    assign rd_idx  = rd_ptr[AW-1:0];
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign commit  = !stall_i && (instr_i != '0) && (state == RUN);
    assign is_halt = instr_i == XLEN'(HALT_INSTR);
    assign pop     = !empty && trace_ready_i;
    // A full FIFO still accepts a record when the head leaves in the same cycle
    assign push    = commit && (!full || pop);
    assign drop    = commit && !push;
    assign rf_we   = commit && (reg_addr_i != 5'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     state_nxt = (commit && is_halt) ? DRAIN : RUN;
            DRAIN:   state_nxt = empty ? DONE : DRAIN;
            default: state_nxt = DONE;
        endcase
    end

    always_comb begin
        halted_o        = state == DONE;
        trace_valid_o   = !empty;
        trace_pc_o      = empty ? '0 : pc_mem[rd_idx];
        trace_instr_o   = empty ? '0 : instr_mem[rd_idx];
        trace_rd_addr_o = empty ? '0 : rd_mem[rd_idx];
        trace_rd_data_o = empty ? '0 : data_mem[rd_idx];
        trace_seq_o     = empty ? '0 : seq_mem[rd_idx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            retired_o  <= '0;
            dropped_o  <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (commit) retired_o <= retired_o + 32'd1;
            if (drop && dropped_o != 16'hFFFF) dropped_o <= dropped_o + 16'd1;
            if (drop) overflow_o <= 1'b1;
        end
    end

    // Storage needs no reset: the outputs are masked while the FIFO is empty
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_idx]    <= pc_i;
            instr_mem[wr_idx] <= instr_i;
            rd_mem[wr_idx]    <= reg_addr_i;
            data_mem[wr_idx]  <= reg_data_i;
            seq_mem[wr_idx]   <= retired_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            dbg_data_o <= '0;
        end else begin
            if (rf_we) rf[reg_addr_i] <= reg_data_i;
            dbg_data_o <= (dbg_addr_i == 5'd0) ? '0 :
                          (rf_we && reg_addr_i == dbg_addr_i) ? reg_data_i : rf[dbg_addr_i];
        end
    end
endmodule

// File: tb/tb_commit_trace_monitor.sv
// tb_commit_trace_monitor: directed checks of the commit trace monitor
module tb_commit_trace_monitor;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i, instr_i, reg_data_i;
    logic [4:0]  reg_addr_i, dbg_addr_i;
    logic        stall_i, trace_ready_i;
    logic        trace_valid_o, overflow_o, halted_o;
    logic [31:0] trace_pc_o, trace_instr_o, trace_rd_data_o, trace_seq_o, dbg_data_o, retired_o;
    logic [4:0]  trace_rd_addr_o;
    logic [15:0] dropped_o;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    commit_trace_monitor dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .instr_i(instr_i),
        .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .stall_i(stall_i),
        .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
        .trace_rd_addr_o(trace_rd_addr_o), .trace_rd_data_o(trace_rd_data_o),
        .trace_seq_o(trace_seq_o), .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o),
        .retired_o(retired_o), .dropped_o(dropped_o), .overflow_o(overflow_o),
        .halted_o(halted_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] instr,
                          input logic [4:0] rd, input logic [31:0] data);
        pc_i = pc; instr_i = instr; reg_addr_i = rd; reg_data_i = data; stall_i = 1'b0;
        step();
        instr_i = '0;
    endtask

    initial begin
        rst_i = 1'b1; pc_i = '0; instr_i = '0; reg_addr_i = '0; reg_data_i = '0;
        stall_i = 1'b0; trace_ready_i = 1'b0; dbg_addr_i = '0;
        step();
        do_reset();
        check("rst_valid", trace_valid_o, 0);
        check("rst_retired", retired_o, 0);
        check("rst_dropped", dropped_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_halted", halted_o, 0);
        check("rst_dbg", dbg_data_o, 0);
        check("rst_trace_pc", trace_pc_o, 0);

        commit(32'h80, 32'h0050_0093, 5'd1, 32'd5);
        check("single_valid", trace_valid_o, 1);
        check("single_pc", trace_pc_o, 32'h80);
        check("single_instr", trace_instr_o, 32'h0050_0093);
        check("single_rd", trace_rd_addr_o, 1);
        check("single_data", trace_rd_data_o, 5);
        check("single_seq", trace_seq_o, 0);
        check("single_retired", retired_o, 1);
        dbg_addr_i = 5'd1;
        step();
        check("single_dbg", dbg_data_o, 5);

        do_reset();
        stall_i = 1'b1; instr_i = 32'h13;
        repeat (3) step();
        stall_i = 1'b0; instr_i = '0;
        step();
        check("stall_valid", trace_valid_o, 0);
        check("stall_retired", retired_o, 0);

        do_reset();
        for (int i = 0; i < 10; i++)
            commit(32'h100 + 4 * i, 32'h13, 5'(i + 1), 3 * i);
        check("ovf_dropped", dropped_o, 2);
        check("ovf_overflow", overflow_o, 1);
        check("ovf_retired", retired_o, 10);
        dbg_addr_i = 5'd10;
        step();
        check("ovf_dbg_dropped_write", dbg_data_o, 27);
        check("ovf_hold_seq", trace_seq_o, 0);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_valid", trace_valid_o, 1);
            check("ovf_drain_seq", trace_seq_o, i);
            check("ovf_drain_pc", trace_pc_o, 32'h100 + 4 * i);
            step();
        end
        check("ovf_drain_empty", trace_valid_o, 0);
        trace_ready_i = 1'b0;

        do_reset();
        for (int i = 0; i < 8; i++) commit(32'h200 + 4 * i, 32'h13, 5'd2, i);
        trace_ready_i = 1'b1;
        commit(32'h300, 32'h13, 5'd2, 32'h99);
        trace_ready_i = 1'b0;
        check("full_pop_dropped", dropped_o, 0);
        check("full_pop_overflow", overflow_o, 0);
        check("full_pop_head", trace_seq_o, 1);
        trace_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("full_pop_seq", trace_seq_o, i);
            step();
        end
        check("full_pop_empty", trace_valid_o, 0);
        trace_ready_i = 1'b0;

        do_reset();
        dbg_addr_i = 5'd0;
        commit(32'h400, 32'h13, 5'd0, 32'hDEAD);
        check("rd0_dbg", dbg_data_o, 0);
        check("rd0_rec_rd", trace_rd_addr_o, 0);
        check("rd0_rec_data", trace_rd_data_o, 32'hDEAD);
        dbg_addr_i = 5'd3;
        commit(32'h404, 32'h13, 5'd3, 32'h77);
        check("bypass_dbg", dbg_data_o, 32'h77);

        do_reset();
        for (int i = 0; i < 3; i++) commit(32'h500 + 4 * i, 32'h13, 5'd4, i);
        commit(32'h50C, 32'h0010_0073, 5'd0, 0);
        commit(32'h510, 32'h13, 5'd5, 1);
        commit(32'h514, 32'h13, 5'd5, 2);
        check("halt_retired", retired_o, 4);
        check("halt_dropped", dropped_o, 0);
        check("halt_not_yet", halted_o, 0);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("halt_drain_seq", trace_seq_o, i);
            check("halt_drain_pc", trace_pc_o, 32'h500 + 4 * i);
            step();
        end
        check("halt_empty", trace_valid_o, 0);
        check("halt_after_pop", halted_o, 0);
        step();
        check("halt_rise", halted_o, 1);
        commit(32'h600, 32'h13, 5'd6, 6);
        check("halt_ignore", trace_valid_o, 0);
        do_reset();
        check("halt_reset", halted_o, 0);
        commit(32'h700, 32'h13, 5'd7, 7);
        check("halt_rerun", retired_o, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/commit_trace_monitor.md
# commit_trace_monitor

Consumer for the core's retirement and trace port. Each cycle it samples `pc`, `instr`, the write-back register address/data and `stall` from the core. For each retired instruction it builds a commit record and queues it in a FIFO. Records drain through a valid/ready stream to the bench or a logger. The block also keeps a shadow architectural register file, readable through a registered debug port, and stops capturing after the core retires `ebreak`.

## Interface
Parameters:
- `XLEN`, 32, datapath width; must match `riscv_pkg::XLEN`.
- `DEPTH`, 8, commit FIFO entries; power of two, ≥2.
- `HALT_INSTR`, 32'h0010_0073, encoding that ends capture (`ebreak`).

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `pc_i`  in  XLEN  retiring PC (core `pc_o`).
- `instr_i`  in  XLEN  retiring instruction (core `instr_o`).
- `reg_addr_i`  in  5  write-back rd; 0 = no write (core `reg_addr_o`).
- `reg_data_i`  in  XLEN  write-back data (core `reg_data_o`).
- `stall_i`  in  1  1 = no retirement this cycle (core `stall_o`).
- `trace_valid_o`  out  1  FIFO head valid.
- `trace_ready_i`  in  1  consumer accepts the head record.
- `trace_pc_o`  out  XLEN  head record PC.
- `trace_instr_o`  out  XLEN  head record instruction.
- `trace_rd_addr_o`  out  5  head record rd.
- `trace_rd_data_o`  out  XLEN  head record rd data.
- `trace_seq_o`  out  32  head record sequence number.
- `dbg_addr_i`  in  5  shadow register read address.
- `dbg_data_o`  out  XLEN  shadow register contents, one cycle after the address.
- `retired_o`  out  32  count of retirements seen.
- `dropped_o`  out  16  count of records lost to a full FIFO; saturates at 16'hFFFF.
- `overflow_o`  out  1  sticky; set on the first drop.
- `halted_o`  out  1  halt instruction retired and FIFO drained.

## Operation
- **Commit condition:** a commit occurs in a cycle when `stall_i`=0, `instr_i`≠0 and the FSM is in `RUN`.
- **Record:** each commit forms the record {`pc_i`, `instr_i`, `reg_addr_i`, `reg_data_i`, `seq`}.
  - `seq` is the current `retired_o` value.
  - `retired_o` then increments by 1 and wraps at 2^32.
- **Shadow register file:** 32×XLEN.
  - On a commit with `reg_addr_i`≠0, entry `reg_addr_i` ← `reg_data_i`.
  - Entry 0 always reads 0.
  - `dbg_data_o` is registered. It returns the post-write value if a write and a read hit the same index in the same cycle.
- **FIFO:** `DEPTH` entries, pointers one bit wider than the index.
  - Push happens on a commit when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the record is dropped: `dropped_o` increments (saturating) and `overflow_o` is set. `retired_o` and the shadow register file still update.
  - Pop happens when `trace_valid_o`=1 and `trace_ready_i`=1.
  - Push and pop in the same cycle leave the occupancy unchanged.
- **FSM:**
  - `RUN`: capture commits. A commit whose `instr_i`==`HALT_INSTR` is recorded normally, then the FSM goes to `DRAIN`.
  - `DRAIN`: ignore all inputs and keep popping. When the FIFO is empty, go to `DONE`.
  - `DONE`: `halted_o`=1. Only reset leaves this state.
- **Reset values:**
  - FIFO empty, `trace_valid_o`=0.
  - Counters 0, `overflow_o`=0, `halted_o`=0.
  - FSM in `RUN`, shadow registers all 0, `dbg_data_o`=0.
  - `trace_*` data outputs 0 while the FIFO is empty.

## Timing
- A commit sampled at edge N is visible at the FIFO head by edge N+1. There is no combinational path from any input to `trace_valid_o`.
- `trace_*` outputs are held stable while `trace_valid_o`=1 and `trace_ready_i`=0.
- `dbg_data_o` latency is 1 cycle.
- The `DRAIN`→`DONE` transition occurs on the edge after the pop that empties the FIFO. `halted_o` rises that same edge.
- A reset asserted mid-stream clears everything on the next edge; records still in the FIFO are discarded.
- Throughput is one commit per cycle sustained when `trace_ready_i` is held at 1.

## Test plan
- **Reset then single commit:** reset, then one commit {pc=0x80, instr=0x00500093, rd=1, data=5} → next cycle `trace_valid_o`=1, pc=0x80, seq=0, `retired_o`=1. Then read `dbg_addr_i`=1 → `dbg_data_o`=5 one cycle later.
- **Stall and zero instruction:** `stall_i`=1 for 3 cycles plus one `instr_i`=0 cycle → no records pushed, `retired_o` stays 0.
- **Overflow with DEPTH=8:** `trace_ready_i`=0, 10 back-to-back commits → FIFO holds seq 0–7, `dropped_o`=2, `overflow_o`=1, `retired_o`=10. Then set ready=1 → exactly 8 records emerge, in order.
- **Full plus simultaneous pop:** fill the FIFO to 8, then commit with ready=1 in the same cycle → no drop, occupancy stays 8.
- **rd=0 write:** commit with rd=0, data=0xDEAD → `dbg_addr_i`=0 reads 0, and the record still carries rd=0, data=0xDEAD.
- **Halt:** 3 commits then `ebreak` with ready=0, followed by further commits → nothing more is captured. Then ready=1 → 4 records drain and `halted_o` rises the cycle after the last pop. Assert `rst_i` → `halted_o`=0 and FSM back in `RUN`.
